// File: rtl/soc_bus_pkg.sv
// Shared bus constants, rw encoding, command FSM state type and protocol byte defaults.
package soc_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [7:0] OP_READ_DEF  = 8'h52;
    localparam logic [7:0] OP_WRITE_DEF = 8'h57;
    localparam logic [7:0] ACK_DEF      = 8'h06;
    localparam logic [7:0] NAK_DEF      = 8'h15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        BUS  = 3'd3,
        RESP = 3'd4
    } state_e;

endpackage

// File: rtl/soc_uart_bus_master.sv
// UART byte-stream command decoder acting as a second initiator on the SoC memory bus.
//
// state | meaning
// IDLE  | waiting for an opcode byte
// ADDR  | shifting in 4 address bytes, MSB first
// DATA  | shifting in 4 write-data bytes, MSB first
// BUS   | valid held until done or timeout
// RESP  | streaming response bytes to the transmitter
module soc_uart_bus_master
    import soc_bus_pkg::*;
#(
    parameter int         TIMEOUT  = 1023,
    parameter logic [7:0] OP_READ  = OP_READ_DEF,
    parameter logic [7:0] OP_WRITE = OP_WRITE_DEF,
    parameter logic [7:0] ACK      = ACK_DEF,
    parameter logic [7:0] NAK      = NAK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              rw,
    output logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] din,
    output logic              valid,
    input  logic              done,
    output logic              busy
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                rw_q, rw_d;
    logic                valid_q, valid_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [DATA_W-1:0]   resp_q, resp_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [15:0]         tmo_q, tmo_d;

    // Register all state; reset abandons any transaction without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            dout_q     <= '0;
            rw_q       <= RW_READ;
            valid_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            resp_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            rw_q       <= rw_d;
            valid_q    <= valid_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            resp_q     <= resp_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state logic: command parsing, bus handshake/timeout and response streaming.
    // cnt counts received bytes in ADDR/DATA and remaining tx bytes in RESP.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        rw_d       = rw_q;
        valid_d    = valid_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        resp_d     = resp_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    cnt_d = 2'd0;
                    if (rx_data == OP_READ || rx_data == OP_WRITE) begin
                        rw_d    = (rx_data == OP_WRITE) ? RW_WRITE : RW_READ;
                        state_d = ADDR;
                    end else begin
                        tx_data_d  = NAK;
                        tx_valid_d = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    addr_d = {addr_q[ADDR_W-9:0], rx_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (rw_q == RW_WRITE) begin
                            state_d = DATA;
                        end else begin
                            state_d = BUS;
                            valid_d = 1'b1;
                            tmo_d   = '0;
                        end
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    dout_d = {dout_q[DATA_W-9:0], rx_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = BUS;
                        valid_d = 1'b1;
                        tmo_d   = '0;
                    end
                end
            end
            BUS: begin
                if (done) begin
                    valid_d    = 1'b0;
                    tx_valid_d = 1'b1;
                    state_d    = RESP;
                    if (rw_q == RW_WRITE) begin
                        tx_data_d = ACK;
                        cnt_d     = 2'd0;
                    end else begin
                        tx_data_d = din[DATA_W-1:DATA_W-8];
                        resp_d    = {din[DATA_W-9:0], 8'h00};
                        cnt_d     = 2'd3;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    valid_d    = 1'b0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = NAK;
                    cnt_d      = 2'd0;
                    state_d    = RESP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            RESP: begin
                if (tx_ready) begin
                    if (cnt_q == 2'd0) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        tx_data_d = resp_q[DATA_W-1:DATA_W-8];
                        resp_d    = {resp_q[DATA_W-9:0], 8'h00};
                        cnt_d     = cnt_q - 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr     = addr_q;
    assign dout     = dout_q;
    assign rw       = rw_q;
    assign valid    = valid_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_soc_uart_bus_master.sv
// Bench for soc_uart_bus_master: directed and random commands against a transaction-level model.
module tb_soc_uart_bus_master;
    import soc_bus_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] addr;
    logic        rw;
    logic [31:0] dout;
    logic [31:0] din;
    logic        valid;
    logic        done;
    logic        busy;

    always #5 clk = ~clk;

    soc_uart_bus_master #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .addr(addr), .rw(rw), .dout(dout), .din(din),
        .valid(valid), .done(done), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Environment state shared between the command driver and the negedge responder/monitor.
    int          valid_cycles;
    int          done_at;
    logic [31:0] bus_din;
    logic [31:0] exp_addr;
    logic [31:0] exp_dout;
    logic        exp_rw;
    int          rdy_mode;
    int          rdy_idx;
    logic [7:0]  tx_q[$];
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic [3:0]  rdy_pat;

    // Bus responder and transmitter model: decides inputs for the next posedge and records accepted bytes.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            done       = 1'b0;
            tx_ready   = 1'b1;
        end else begin
            if (prev_stall) begin
                chk("stall_tx_valid", tx_valid, 1'b1);
                chk("stall_tx_data", tx_data, prev_data);
            end
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       begin tx_ready = rdy_pat[3 - (rdy_idx % 4)]; rdy_idx++; end
                default: tx_ready = 1'($urandom % 2);
            endcase
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;

            if (valid) begin
                valid_cycles++;
                chk("bus_addr", addr, exp_addr);
                chk("bus_rw", rw, exp_rw);
                if (exp_rw) chk("bus_dout", dout, exp_dout);
                done = (valid_cycles == done_at);
                din  = done ? bus_din : $urandom;
            end else begin
                done = (($urandom % 8) == 0);
                din  = $urandom;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic setup(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input int dat, input logic [31:0] rdin, input int mode);
        valid_cycles = 0;
        tx_q.delete();
        done_at  = dat;
        bus_din  = rdin;
        exp_addr = a;
        exp_dout = d;
        exp_rw   = (op == OP_WRITE_DEF);
        rdy_mode = mode;
        rdy_idx  = 0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        send_byte(op);
        if (op == OP_READ_DEF || op == OP_WRITE_DEF) begin
            for (int i = 3; i >= 0; i--) send_byte(8'((a / (32'd1 << (8 * i))) % 256));
            if (op == OP_WRITE_DEF)
                for (int i = 3; i >= 0; i--) send_byte(8'((d / (32'd1 << (8 * i))) % 256));
        end
    endtask

    // One full command: drive bytes, wait for completion, compare against the transaction model.
    task automatic run_cmd(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] d, input int dat, input logic [31:0] rdin,
                           input int mode, input bit junk);
        logic [7:0] exp_q[$];
        int exp_vc;
        int n;
        bit good_op;
        bit finished;
        setup(op, a, d, dat, rdin, mode);
        send_cmd(op, a, d);
        chk({tag, "_busy"}, busy, 1'b1);

        good_op  = (op == OP_READ_DEF) || (op == OP_WRITE_DEF);
        finished = good_op && dat >= 1 && dat <= TMO;
        if (!good_op) begin
            exp_vc = 0;
            exp_q.push_back(NAK_DEF);
        end else begin
            exp_vc = finished ? dat : TMO;
            if (!finished) exp_q.push_back(NAK_DEF);
            else if (op == OP_WRITE_DEF) exp_q.push_back(ACK_DEF);
            else for (int i = 3; i >= 0; i--) exp_q.push_back(8'((rdin / (32'd1 << (8 * i))) % 256));
        end

        n = 0;
        while (busy === 1'b1 && n < 300) begin
            if (junk) begin
                rx_valid = 1'($urandom % 2);
                rx_data  = (($urandom % 2) == 0) ? OP_READ_DEF : 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
        rx_valid = 1'b0;
        chk({tag, "_completes"}, 32'(n < 300), 32'd1);
        chk({tag, "_valid_cycles"}, valid_cycles, exp_vc);
        chk({tag, "_tx_count"}, tx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
            chk({tag, "_tx_byte"}, tx_q[i], exp_q[i]);
    endtask

    initial begin
        int n;
        logic [7:0]  op;
        logic [31:0] ra;
        logic [31:0] rd;
        rdy_pat  = 4'b1001;
        rdy_mode = 0;
        rdy_idx  = 0;
        done_at  = 0;
        valid_cycles = 0;
        prev_stall = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        done     = 1'b0;
        din      = '0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_dout", dout, 32'h0);
        chk("rst_rw", rw, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        run_cmd("write", OP_WRITE_DEF, 32'h0000_0100, 32'hDEAD_BEEF, 4, 32'h0, 0, 0);
        run_cmd("read", OP_READ_DEF, 32'h0000_0100, 32'h0, 1, 32'h1234_5678, 0, 0);
        run_cmd("read_bp", OP_READ_DEF, 32'h0000_0100, 32'h0, 2, 32'h1234_5678, 1, 0);
        run_cmd("bad_op", 8'h41, 32'h0, 32'h0, 1, 32'h0, 0, 0);
        run_cmd("read_after_nak", OP_READ_DEF, 32'hCAFE_0004, 32'h0, 3, 32'hA5A5_5A5A, 0, 0);
        run_cmd("timeout", OP_WRITE_DEF, 32'h0000_0200, 32'h1111_2222, 0, 32'h0, 0, 0);
        run_cmd("done_at_tc", OP_WRITE_DEF, 32'h0000_0204, 32'h3333_4444, TMO, 32'h0, 0, 0);
        run_cmd("read_timeout", OP_READ_DEF, 32'h0000_0208, 32'h0, 0, 32'h0, 2, 1);

        // Reset while the bus request is outstanding.
        setup(OP_WRITE_DEF, 32'h0000_0300, 32'h5555_6666, 0, 32'h0, 0);
        send_cmd(OP_WRITE_DEF, 32'h0000_0300, 32'h5555_6666);
        n = 0;
        while (valid_cycles < 3 && n < 50) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            @(negedge clk);
            n++;
        end
        rx_valid = 1'b0;
        chk("rst_mid_reached_bus", 32'(n < 50), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", valid, 1'b0);
        chk("rst_mid_tx_valid", tx_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_resp", tx_q.size(), 0);
        run_cmd("read_after_rst", OP_READ_DEF, 32'h0000_0300, 32'h0, 2, 32'h0BAD_F00D, 1, 1);

        for (int k = 0; k < 24; k++) begin
            case ($urandom % 5)
                0, 1:    op = OP_READ_DEF;
                2, 3:    op = OP_WRITE_DEF;
                default: op = 8'($urandom);
            endcase
            ra = $urandom;
            rd = $urandom;
            run_cmd("random", op, ra, rd, int'($urandom_range(0, TMO + 2)), $urandom,
                    int'($urandom % 3), 1'($urandom % 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_uart_bus_master.md
Name: soc_uart_bus_master

Overview:
- Serial debug/boot bridge: decodes a byte-stream command protocol from the UART receiver and acts as a second initiator on the SoC memory bus (addr/rw/dout/din/valid/done).
- Reads or writes one 32-bit word per command and returns the result to the UART transmitter as a byte stream.
- Sits between the UART byte interfaces and the bus arbiter/BRAM. Used to load programs into BRAM and inspect memory while the CPU is held off through busy.

Parameters:
- TIMEOUT, 1023: bus cycles to wait for done before aborting the transaction; valid range 1..65535.
- OP_READ, 8'h52: opcode byte for read ('R').
- OP_WRITE, 8'h57: opcode byte for write ('W').
- ACK, 8'h06: response byte for a completed write.
- NAK, 8'h15: response byte for a bad opcode or a timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid & tx_ready.
- addr  out  32  bus address.
- rw  out  1  1 = write, 0 = read.
- dout  out  32  bus write data.
- din  in  32  bus read data, valid in the done cycle.
- valid  out  1  bus request; held until done or timeout.
- done  in  1  one-cycle responder completion strobe.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE; addr=0, dout=0, rw=0, valid=0, tx_valid=0, tx_data=0, busy=0; all counters=0. Reset mid-transaction aborts immediately with no response.
- Byte order: address and data are sent most-significant byte first, in both directions.
- IDLE:
  - rx byte == OP_READ or OP_WRITE: latch rw (write=1), clear byte count, go to ADDR.
  - Any other byte: load NAK, go to RESP.
- ADDR: each rx byte shifts into addr (addr <= {addr[23:0], byte}). After the 4th byte: write goes to DATA, read goes to BUS.
- DATA: each rx byte shifts into dout the same way. After the 4th byte, go to BUS.
- BUS:
  - valid=1 from the cycle after the last command byte is accepted. addr, rw and dout stay stable while valid=1.
  - Timeout counter clears on entry and increments each cycle valid=1 and done=0.
  - done=1: valid drops the next cycle. A read captures din into the 32-bit response register; a write loads ACK. Go to RESP.
  - Counter reaches TIMEOUT-1 with done=0: valid drops the next cycle, load NAK, go to RESP.
  - done and the terminal count in the same cycle: done wins.
- RESP:
  - tx_valid=1 from the cycle after entry; tx_data is stable while tx_valid=1 and tx_ready=0.
  - A read sends 4 bytes, MSB first. ACK and NAK send 1 byte.
  - Each tx_valid & tx_ready advances to the next byte on the following cycle. After the final accept, tx_valid=0 and state returns to IDLE.
- rx bytes arriving in BUS or RESP are discarded. No inter-byte timeout.
- done while valid=0 is ignored.
- Back-to-back: a new opcode is accepted in the first IDLE cycle after RESP.
- rw is the latched command value; it only matters while valid=1.

Decomposition:
- Shared package soc_bus_pkg: bus width constants (ADDR_W=32, DATA_W=32), rw encoding (RW_READ=0, RW_WRITE=1), state enum {IDLE, ADDR, DATA, BUS, RESP}, opcode/ACK/NAK defaults.
- No sub-module; the 2-bit byte counter, timeout counter and response shifter are all local.
- The UART bit-level rx/tx stay external.

Test Plan:
- Write: rx 57 00 00 01 00 DE AD BE EF; responder asserts done 3 cycles after valid -> bus shows addr=0x00000100, rw=1, dout=0xDEADBEEF held until done; then tx ACK 06.
- Read: rx 52 00 00 01 00; din=0x12345678 with done -> rw=0, valid drops next cycle; tx 12 34 56 78 in order.
- Backpressure: same read with tx_ready toggling 1-0-0-1 -> each tx_data stable while stalled; 4 bytes sent, no duplicates or drops.
- Bad opcode: rx 41 -> tx 15 only, no valid pulse; a following valid read command completes normally.
- Timeout with TIMEOUT=8: write command, done never asserted -> valid high exactly 8 cycles, then tx 15. done=1 in the 8th cycle instead -> ACK 06.
- Reset mid-BUS: assert reset while valid=1 -> next cycle valid=0, tx_valid=0, busy=0; extra rx bytes during BUS/RESP are ignored.
